// File: rtl/msu_data_prefetch.sv
// Sequential byte-stream prefetcher: fetches 16-bit words from memory into a byte FIFO after a seek.
// Define MSU_PREFETCH_DEEP_EN for a 64-byte FIFO; the default build uses a 16-byte FIFO.
module msu_data_prefetch (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        seek,
    input  logic [31:0] seek_addr,
    input  logic        advance,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        underrun,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data
);

`ifdef MSU_PREFETCH_DEEP_EN
    localparam int DEPTH = 64;
`else
    localparam int DEPTH = 16;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_ptr;
    logic [31:0]   req_addr;
    logic [LW-1:0] level;
    logic [LW-1:0] free;
    logic [AW-1:0] rptr, wptr;
    logic [7:0]    fifo [DEPTH];
    logic [7:0]    last_q;
    logic          active;
    logic          take;
    logic          pop;
    logic          odd;
    logic [1:0]    push_n;

    // An ack that coincides with a seek belongs to the old stream and is dropped.
    always_comb begin
        take   = (state == FETCH) && mem_ack && !seek;
        odd    = fetch_ptr[0];
        push_n = take ? (odd ? 2'd1 : 2'd2) : 2'd0;
        pop    = advance && !seek && (level != '0);
        free   = LW'(DEPTH) - level;
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Any ack ends the outstanding request, so a seek racing an ack returns to IDLE
    // rather than waiting in FLUSH for an ack that will never come.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!seek && active && free >= LW'(2)) state_nxt = FETCH;
            FETCH:   if (mem_ack) state_nxt = IDLE;
                     else if (seek) state_nxt = FLUSH;
            FLUSH:   if (mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state != IDLE);
        mem_addr = req_addr;
        data_out = (level != '0) ? fifo[rptr] : last_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_ptr <= '0;
            req_addr  <= '0;
            level     <= '0;
            rptr      <= '0;
            wptr      <= '0;
            last_q    <= '0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
            active    <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == FETCH)
                req_addr <= {fetch_ptr[31:1], 1'b0};
            // Remember the displayed head so data_out holds once the FIFO drains.
            if (level != '0)
                last_q <= fifo[rptr];
            if (seek) begin
                fetch_ptr <= seek_addr;
                level     <= '0;
                rptr      <= '0;
                wptr      <= '0;
                busy      <= 1'b1;
                underrun  <= 1'b0;
                active    <= 1'b1;
            end else begin
                if (take) begin
                    fetch_ptr <= fetch_ptr + (odd ? 32'd1 : 32'd2);
                    wptr      <= wptr + AW'(push_n);
                    busy      <= 1'b0;
                end
                if (pop)
                    rptr <= rptr + AW'(1);
                if (advance && level == '0)
                    underrun <= 1'b1;
                level <= level + LW'(push_n) - LW'(pop);
            end
        end
    end

    // An odd stream position keeps only the high byte of the word.
    always_ff @(posedge CLK) begin
        if (take) begin
            if (odd) begin
                fifo[wptr] <= mem_data[15:8];
            end else begin
                fifo[wptr]          <= mem_data[7:0];
                fifo[wptr + AW'(1)] <= mem_data[15:8];
            end
        end
    end

endmodule

// File: tb/tb_msu_data_prefetch.sv
// Scoreboard bench for msu_data_prefetch: bytes returned by the memory stub are queued
// and compared against data_out as the consumer advances.
module tb_msu_data_prefetch;

`ifdef MSU_PREFETCH_DEEP_EN
    localparam int DEPTH = 64;
`else
    localparam int DEPTH = 16;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        seek = 1'b0;
    logic [31:0] seek_addr = '0;
    logic        advance = 1'b0;
    logic [7:0]  data_out;
    logic        busy;
    logic        underrun;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = '0;

    int vec = 0;
    int miss = 0;
    logic [7:0] sb[$];
    logic [7:0] exp;

    msu_data_prefetch dut (
        .CLK(CLK), .RESET(RESET), .seek(seek), .seek_addr(seek_addr), .advance(advance),
        .data_out(data_out), .busy(busy), .underrun(underrun), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        RESET = 1'b1; seek = 1'b0; advance = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        sb.delete();
    endtask

    task automatic do_seek(input logic [31:0] a);
        seek = 1'b1; seek_addr = a;
        tick();
        seek = 1'b0;
    endtask

    task automatic give_ack(input logic [15:0] w);
        mem_ack = 1'b1; mem_data = w;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic pulse_adv();
        advance = 1'b1;
        tick();
        advance = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bit seen;
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        vec++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin miss++; $display("FAIL reset_mem req=%b addr=%h exp 0/0", mem_req, mem_addr); end
        vec++; if (data_out !== 8'h00) begin miss++; $display("FAIL reset_data data_out=%h exp 00", data_out); end
        vec++; if (busy !== 1'b0 || underrun !== 1'b0) begin miss++; $display("FAIL reset_flags busy=%b underrun=%b exp 0/0", busy, underrun); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        vec++; if (seen) begin miss++; $display("FAIL no_seek_idle req/busy seen before seek, exp none"); end
    endtask

    task automatic test_aligned();
        bit ok;
        apply_reset();
        do_seek(32'h0000_0100);
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL aligned_busy_set busy=%b exp 1", busy); end
        wait_req(ok);
        vec++; if (!ok || mem_addr !== 32'h100) begin miss++; $display("FAIL aligned_addr req=%b addr=%h exp 1/00000100", ok, mem_addr); end
        mem_ack = 1'b1; mem_data = 16'hBBAA;
        sb.push_back(8'hAA); sb.push_back(8'hBB);
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL aligned_busy_pre busy=%b exp 1", busy); end
        tick();
        mem_ack = 1'b0;
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL aligned_busy_fall busy=%b exp 0", busy); end
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL aligned_d0 data_out=%h exp %h", data_out, exp); end
        pulse_adv();
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL aligned_d1 data_out=%h exp %h", data_out, exp); end
    endtask

    task automatic test_odd();
        bit ok;
        apply_reset();
        do_seek(32'h0000_0101);
        wait_req(ok);
        vec++; if (!ok || mem_addr !== 32'h100) begin miss++; $display("FAIL odd_addr0 req=%b addr=%h exp 1/00000100", ok, mem_addr); end
        sb.push_back(8'hBB);
        give_ack(16'hBBAA);
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL odd_d0 data_out=%h exp %h", data_out, exp); end
        pulse_adv();
        vec++; if (underrun !== 1'b0 || data_out !== 8'hBB) begin miss++; $display("FAIL odd_hold underrun=%b data_out=%h exp 0/bb", underrun, data_out); end
        wait_req(ok);
        vec++; if (!ok || mem_addr !== 32'h102) begin miss++; $display("FAIL odd_addr1 req=%b addr=%h exp 1/00000102", ok, mem_addr); end
        sb.push_back(8'hCC); sb.push_back(8'hDD);
        give_ack(16'hDDCC);
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL odd_d1 data_out=%h exp %h", data_out, exp); end
        pulse_adv();
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL odd_d2 data_out=%h exp %h", data_out, exp); end
    endtask

    task automatic test_seek_mid_fetch();
        bit ok;
        apply_reset();
        do_seek(32'h0000_0200);
        wait_req(ok);
        vec++; if (!ok || mem_addr !== 32'h200) begin miss++; $display("FAIL mid_addr0 req=%b addr=%h exp 1/00000200", ok, mem_addr); end
        do_seek(32'h0000_0400);
        vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin miss++; $display("FAIL mid_stale req=%b addr=%h exp 1/00000200", mem_req, mem_addr); end
        give_ack(16'h1111);
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL mid_busy_discard busy=%b exp 1", busy); end
        wait_req(ok);
        vec++; if (!ok || mem_addr !== 32'h400) begin miss++; $display("FAIL mid_addr1 req=%b addr=%h exp 1/00000400", ok, mem_addr); end
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL mid_busy_hold busy=%b exp 1", busy); end
        sb.push_back(8'h33); sb.push_back(8'h22);
        give_ack(16'h2233);
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL mid_busy_fall busy=%b exp 0", busy); end
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL mid_d0 data_out=%h exp %h", data_out, exp); end
    endtask

    task automatic test_fill();
        bit ok;
        bit seen;
        apply_reset();
        do_seek(32'h0);
        for (int k = 0; k < DEPTH / 2; k++) begin
            wait_req(ok);
            vec++; if (!ok || mem_addr !== 32'(2 * k)) begin miss++; $display("FAIL fill_addr k=%0d req=%b addr=%h exp 1/%h", k, ok, mem_addr, 32'(2 * k)); end
            sb.push_back(8'(2 * k)); sb.push_back(8'(2 * k + 1));
            give_ack({8'(2 * k + 1), 8'(2 * k)});
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req !== 1'b0) seen = 1'b1;
            tick();
        end
        vec++; if (seen) begin miss++; $display("FAIL fill_stall mem_req rose at full level, exp 0"); end
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL fill_head data_out=%h exp %h", data_out, exp); end
        pulse_adv();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== 1'b0) seen = 1'b1;
            tick();
        end
        vec++; if (seen) begin miss++; $display("FAIL fill_one_free mem_req rose with 1 free byte, exp 0"); end
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL fill_head2 data_out=%h exp %h", data_out, exp); end
        pulse_adv();
        wait_req(ok);
        vec++; if (!ok || mem_addr !== 32'(DEPTH)) begin miss++; $display("FAIL fill_resume req=%b addr=%h exp 1/%h", ok, mem_addr, 32'(DEPTH)); end
        sb.push_back(8'hE0); sb.push_back(8'hE1);
        give_ack(16'hE1E0);
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            vec++; if (data_out !== exp) begin miss++; $display("FAIL fill_drain data_out=%h exp %h", data_out, exp); end
            pulse_adv();
        end
        vec++; if (underrun !== 1'b0) begin miss++; $display("FAIL fill_underrun underrun=%b exp 0", underrun); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        apply_reset();
        do_seek(32'h0);
        wait_req(ok);
        sb.push_back(8'hA0); sb.push_back(8'hA1);
        give_ack(16'hA1A0);
        wait_req(ok);
        vec++; if (!ok || mem_addr !== 32'h2) begin miss++; $display("FAIL b2b_addr req=%b addr=%h exp 1/00000002", ok, mem_addr); end
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL b2b_head data_out=%h exp %h", data_out, exp); end
        mem_ack = 1'b1; mem_data = 16'hB1B0; advance = 1'b1;
        sb.push_back(8'hB0); sb.push_back(8'hB1);
        tick();
        mem_ack = 1'b0; advance = 1'b0;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            vec++; if (data_out !== exp) begin miss++; $display("FAIL b2b_drain data_out=%h exp %h", data_out, exp); end
            pulse_adv();
        end
    endtask

    task automatic test_underrun();
        bit ok;
        apply_reset();
        do_seek(32'h0000_0300);
        wait_req(ok);
        sb.push_back(8'h44); sb.push_back(8'h55);
        give_ack(16'h5544);
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL urun_d0 data_out=%h exp %h", data_out, exp); end
        // seek and advance together: the pop is dropped and no underrun is flagged
        seek = 1'b1; seek_addr = 32'h0000_0500; advance = 1'b1;
        tick();
        seek = 1'b0; advance = 1'b0;
        vec++; if (underrun !== 1'b0 || data_out !== 8'h44) begin miss++; $display("FAIL urun_seek_wins underrun=%b data_out=%h exp 0/44", underrun, data_out); end
        pulse_adv();
        vec++; if (underrun !== 1'b1) begin miss++; $display("FAIL urun_set underrun=%b exp 1", underrun); end
        vec++; if (data_out !== 8'h44) begin miss++; $display("FAIL urun_hold data_out=%h exp 44", data_out); end
        tick(); tick();
        vec++; if (underrun !== 1'b1) begin miss++; $display("FAIL urun_sticky underrun=%b exp 1", underrun); end
        do_seek(32'h0000_0600);
        vec++; if (underrun !== 1'b0) begin miss++; $display("FAIL urun_clear underrun=%b exp 0", underrun); end
    endtask

    task automatic test_wrap_reset();
        bit ok;
        bit seen;
        apply_reset();
        do_seek(32'hFFFF_FFFE);
        wait_req(ok);
        vec++; if (!ok || mem_addr !== 32'hFFFF_FFFE) begin miss++; $display("FAIL wrap_addr0 req=%b addr=%h exp 1/fffffffe", ok, mem_addr); end
        sb.push_back(8'h11); sb.push_back(8'h22);
        give_ack(16'h2211);
        exp = sb.pop_front();
        vec++; if (data_out !== exp) begin miss++; $display("FAIL wrap_d0 data_out=%h exp %h", data_out, exp); end
        wait_req(ok);
        vec++; if (!ok || mem_addr !== 32'h0) begin miss++; $display("FAIL wrap_addr1 req=%b addr=%h exp 1/00000000", ok, mem_addr); end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        mem_ack = 1'b1; mem_data = 16'h9999;
        sb.delete();
        vec++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin miss++; $display("FAIL wrap_rst_mem req=%b addr=%h exp 0/0", mem_req, mem_addr); end
        vec++; if (data_out !== 8'h00 || busy !== 1'b0 || underrun !== 1'b0) begin miss++; $display("FAIL wrap_rst_out data_out=%h busy=%b underrun=%b exp 00/0/0", data_out, busy, underrun); end
        tick();
        mem_ack = 1'b0;
        vec++; if (mem_req !== 1'b0 || data_out !== 8'h00 || busy !== 1'b0) begin miss++; $display("FAIL wrap_late_ack req=%b data_out=%h busy=%b exp 0/00/0", mem_req, data_out, busy); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (mem_req !== 1'b0) seen = 1'b1;
            tick();
        end
        vec++; if (seen) begin miss++; $display("FAIL wrap_inactive mem_req rose after reset, exp 0"); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_odd();
        test_seek_mid_fetch();
        test_fill();
        test_back_to_back();
        test_underrun();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
